// File: rtl/seg7_display_sched.sv
// Round-robin display scheduler for three game values: grants one source, converts
// its saturated binary value to four BCD digits by double-dabble, then holds the display.
module seg7_display_sched #(
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [13:0] val0,
  input  logic [13:0] val1,
  input  logic [13:0] val2,
  output logic [2:0]  gnt,
  output logic        upd,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands
);

  localparam int              HW        = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [13:0]     BIN_MAX   = 14'd9999;

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          upd_q, upd_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    iter_q, iter_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   digits_q, digits_d;

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  logic [1:0]  cand1, cand2, pick;
  logic [13:0] sel_val;

  always_comb begin
    cand1 = rr_next(last_q);
    cand2 = rr_next(cand1);
    if (req[cand1])      pick = cand1;
    else if (req[cand2]) pick = cand2;
    else                 pick = last_q;
    case (pick)
      2'd0:    sel_val = val0;
      2'd1:    sel_val = val1;
      default: sel_val = val2;
    endcase
  end

  // Add-3 correction on every nibble before each shift keeps each digit in 0-9.
  logic [15:0] bcd_adj;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                             : bcd_q[gi*4 +: 4];
    end
  endgenerate

  logic [15:0] bcd_shift;
  logic [13:0] bin_shift;
  assign bcd_shift = {bcd_adj[14:0], bin_q[13]};
  assign bin_shift = {bin_q[12:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    upd_d    = 1'b0;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    hold_d   = hold_q;
    digits_d = digits_q;
    case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        if (|req) begin
          state_d = CONV;
          last_d  = pick;
          gnt_d   = 3'b001 << pick;
          bin_d   = (sel_val > BIN_MAX) ? BIN_MAX : sel_val;
          bcd_d   = 16'd0;
          iter_d  = 4'd0;
        end
      end
      CONV: begin
        bcd_d  = bcd_shift;
        bin_d  = bin_shift;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) begin
          digits_d = bcd_shift;
          upd_d    = 1'b1;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!(|(req & gnt_q)) || hold_q == HOLD_LAST) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 2'd2;
      gnt_q    <= 3'b000;
      upd_q    <= 1'b0;
      bin_q    <= 14'd0;
      bcd_q    <= 16'd0;
      iter_q   <= 4'd0;
      hold_q   <= '0;
      digits_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      upd_q    <= upd_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      hold_q   <= hold_d;
      digits_q <= digits_d;
    end
  end

  assign gnt       = gnt_q;
  assign upd       = upd_q;
  assign thousands = digits_q[15:12];
  assign hundreds  = digits_q[11:8];
  assign tens      = digits_q[7:4];
  assign ones      = digits_q[3:0];

endmodule
